// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and types for the fetch stage.
package mips_pkg;

  // Next-PC select driven by the decode-stage branch unit
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_J   = 2'b01;
  localparam logic [1:0] PC_BR  = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational redirect-target computation for j/jal, branch, jr/jalr.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [1:0]  pc_src,
  input  logic [31:0] id_pc_plus4,
  input  logic [25:0] id_jindex,
  input  logic [15:0] id_imm,
  input  logic [31:0] id_rs,
  output logic [31:0] target
);

  // Select the control-transfer target; branch offset is sign-extended and scaled by 4
  always_comb begin
    target = id_pc_plus4;
    unique case (pc_src)
      PC_J:    target = {id_pc_plus4[31:28], id_jindex, 2'b00};
      PC_BR:   target = id_pc_plus4 + {{14{id_imm[15]}}, id_imm, 2'b00};
      PC_JR:   target = id_rs;
      default: target = id_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: fetch stage owning the PC, single outstanding imem request,
// valid/ready delivery to decode, redirect with wrong-path squash.
// Optional macro DELAY_SLOT_EN: MIPS branch delay slot instead of flush.
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src,
  input  logic        id_valid,
  input  logic [31:0] id_pc_plus4,
  input  logic [25:0] id_jindex,
  input  logic [15:0] id_imm,
  input  logic [31:0] id_rs,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        id_ready
);

  fetch_state_t state, state_next;

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_en_q;
  logic        squash_q, squash_d;
  logic        if_valid_d;
  logic [31:0] if_instr_d, if_pc_d, if_pc_plus4_d;
  logic [31:0] target;
  logic        redirect, acked, discard, flush;

  next_pc_calc u_next_pc (
    .pc_src      (pc_src),
    .id_pc_plus4 (id_pc_plus4),
    .id_jindex   (id_jindex),
    .id_imm      (id_imm),
    .id_rs       (id_rs),
    .target      (target)
  );

  assign redirect = id_valid && (pc_src != PC_SEQ);
  assign acked    = imem_req && imem_ack;

`ifdef DELAY_SLOT_EN
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic        take_redirect;

  // A branch sitting in a delay slot is undefined, so only the first redirect counts
  assign take_redirect = redirect && !pend_valid_q;
  assign discard       = 1'b0;
  assign flush         = 1'b0;
`else
  assign discard = squash_q || redirect;
  assign flush   = redirect;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state: one request in flight, hold the word until decode takes it
  always_comb begin
    state_next = state;
    unique case (state)
      FETCH:   if (req_en_q) state_next = imem_ack ? (discard ? FETCH : HOLD) : WAIT;
      WAIT:    if (imem_ack) state_next = discard ? FETCH : HOLD;
      HOLD:    if (flush || id_ready) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Request outputs: a new request presents the aligned PC, a pending one its latched address
  always_comb begin
    imem_req  = req_en_q && (state != HOLD);
    imem_addr = (state == FETCH) ? word_align(pc_q) : req_addr_q;
  end

  // Datapath next values. pc may move to a redirect target while a request is
  // pending, so the in-flight address lives separately in req_addr.
  always_comb begin
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    squash_d      = squash_q;
    if_valid_d    = if_valid;
    if_instr_d    = if_instr;
    if_pc_d       = if_pc;
    if_pc_plus4_d = if_pc_plus4;
`ifdef DELAY_SLOT_EN
    pend_pc_d     = pend_pc_q;
    pend_valid_d  = pend_valid_q;
`endif
    if (imem_req) req_addr_d = imem_addr;
    if (acked) begin
      squash_d = 1'b0;
      if (!discard) begin
        if_valid_d    = 1'b1;
        if_instr_d    = imem_rdata;
        if_pc_d       = imem_addr;
        if_pc_plus4_d = imem_addr + 32'd4;
        pc_d          = imem_addr + 32'd4;
      end
    end
    if ((state == HOLD) && (flush || id_ready)) if_valid_d = 1'b0;
`ifdef DELAY_SLOT_EN
    if (take_redirect) begin
      if ((state == HOLD) || acked) begin
        pc_d = target;
      end else begin
        pend_pc_d    = target;
        pend_valid_d = 1'b1;
      end
    end
    if (pend_valid_q && acked) begin
      pc_d         = pend_pc_q;
      pend_valid_d = 1'b0;
    end
`else
    if (redirect) begin
      pc_d = target;
      if (imem_req && !imem_ack) squash_d = 1'b1;
    end
`endif
  end

  // Datapath registers; req_en delays the first request by one cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      req_en_q     <= 1'b0;
      squash_q     <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      if_pc_plus4  <= '0;
`ifdef DELAY_SLOT_EN
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      req_en_q     <= 1'b1;
      squash_q     <= squash_d;
      if_valid     <= if_valid_d;
      if_instr     <= if_instr_d;
      if_pc        <= if_pc_d;
      if_pc_plus4  <= if_pc_plus4_d;
`ifdef DELAY_SLOT_EN
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed stimulus with a transaction-level model of the fetch stage.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic        id_valid;
  logic [31:0] id_pc_plus4;
  logic [25:0] id_jindex;
  logic [15:0] id_imm;
  logic [31:0] id_rs;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        id_ready;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_src      (pc_src),
    .id_valid    (id_valid),
    .id_pc_plus4 (id_pc_plus4),
    .id_jindex   (id_jindex),
    .id_imm      (id_imm),
    .id_rs       (id_rs),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4),
    .id_ready    (id_ready)
  );

  // Instruction memory contents: every word is its address xor a tag
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int unsigned nerr = 0;
  int unsigned nchk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ack after ack_lat cycles of a request being up
  int unsigned ack_lat = 0;
  int unsigned wcnt = 0;
  initial begin
    imem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || (imem_req && imem_ack)) wcnt = 0;
      else if (imem_req) wcnt++;
      @(posedge clk);
      #1;
      imem_ack = imem_req && !rst && (wcnt >= ack_lat);
    end
  end

  // Architectural target rules
  function automatic logic [31:0] model_target(input logic [1:0] src, input logic [31:0] pc4,
                                               input logic [25:0] j, input logic [15:0] imm,
                                               input logic [31:0] rs);
    case (src)
      2'b01:   return {pc4[31:28], j, 2'b00};
      2'b10:   return pc4 + 32'(int'($signed(imm)) * 4);
      2'b11:   return rs;
      default: return pc4;
    endcase
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] plus4;
  } del_t;

  del_t        del_log[$];
  logic [31:0] req_log[$];

  logic [31:0] m_next = 32'h0;
  logic [31:0] m_req_addr = 32'h0;
  logic        m_in_req = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_del = 1'b0;
  logic [31:0] m_del_pc = 32'h0;
  int unsigned m_req_len = 0;
  int unsigned last_req_len = 0;

  // Model and compare: one request at a time, stale words never delivered
  always @(negedge clk) begin
    logic        redir;
    logic [31:0] tgt;
    if (rst) begin
      m_next   = 32'h0;
      m_in_req = 1'b0;
      m_stale  = 1'b0;
      m_del    = 1'b0;
    end else begin
      redir = id_valid && (pc_src != 2'b00);
      tgt   = model_target(pc_src, id_pc_plus4, id_jindex, id_imm, id_rs) & ~32'h3;
      chk("if_valid", 32'(if_valid), 32'(m_del));
      if (m_del) begin
        chk("if_pc", if_pc, m_del_pc);
        chk("if_instr", if_instr, mem_word(m_del_pc));
        chk("if_pc_plus4", if_pc_plus4, m_del_pc + 32'd4);
        chk("req_while_held", 32'(imem_req), 32'd0);
        if (redir) m_del = 1'b0;
        else if (id_ready) begin
          del_log.push_back('{pc: if_pc, instr: if_instr, plus4: if_pc_plus4});
          m_del = 1'b0;
        end
      end
      if (imem_req) begin
        if (!m_in_req) begin
          chk("req_addr_start", imem_addr, m_next);
          m_in_req   = 1'b1;
          m_req_addr = m_next;
          m_next     = m_next + 32'd4;
          m_req_len  = 0;
          req_log.push_back(imem_addr);
        end else begin
          chk("req_addr_stable", imem_addr, m_req_addr);
        end
        m_req_len++;
        if (redir) begin
          m_stale = 1'b1;
          m_next  = tgt;
        end
        if (imem_ack) begin
          m_in_req     = 1'b0;
          last_req_len = m_req_len;
          if (!m_stale) begin
            m_del    = 1'b1;
            m_del_pc = m_req_addr;
          end
          m_stale = 1'b0;
        end
      end else begin
        chk("req_dropped", 32'(imem_req), 32'(m_in_req));
        if (redir) m_next = tgt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    del_log.delete();
    req_log.delete();
  endtask

  task automatic park();
    id_ready = 1'b0;
    for (int i = 0; i < 40 && !if_valid; i++) tick();
    chk("park_valid", 32'(if_valid), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !if_valid; i++) tick();
    chk("wait_valid", 32'(if_valid), 32'd1);
  endtask

  task automatic wait_del(input int n, input int budget);
    for (int i = 0; i < budget && del_log.size() < n; i++) tick();
    chk("wait_deliveries", 32'(del_log.size() >= n), 32'd1);
  endtask

  task automatic redirect(input logic [1:0] src, input logic [31:0] pc4, input logic [25:0] j,
                          input logic [15:0] imm, input logic [31:0] rs);
    pc_src      = src;
    id_pc_plus4 = pc4;
    id_jindex   = j;
    id_imm      = imm;
    id_rs       = rs;
    id_valid    = 1'b1;
    tick();
    id_valid = 1'b0;
    pc_src   = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_instr"}, if_instr, 32'h0);
    chk({tag, "_if_pc"}, if_pc, 32'h0);
    chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; pc_src = 2'b00; id_pc_plus4 = '0;
    id_jindex = '0; id_imm = '0; id_rs = '0; id_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Sequential fetch, ack and ready tied high
    id_ready = 1'b1;
    wait_del(4, 60);
    for (int i = 0; i < 4; i++) begin
      chk("seq_req_addr", req_log[i], 32'(i * 4));
      chk("seq_if_pc", del_log[i].pc, 32'(i * 4));
    end
    chk("seq_instr0", del_log[0].instr, 32'hDEAD_0000);
    chk("seq_plus4_3", del_log[3].plus4, 32'h0000_0010);

    // jr redirect with id_ready=1 in the same cycle: held word flushed
    park();
    ack_lat = 0;
    clear_logs();
    id_ready = 1'b1;
    redirect(2'b11, 32'h0, 26'h0, 16'h0, 32'h1234_5678);
    id_ready = 1'b0;
    wait_valid(20);
    chk("jr_flush_no_transfer", 32'(del_log.size()), 32'd0);
    chk("jr_req_addr", req_log[0], 32'h1234_5678);
    chk("jr_if_pc", if_pc, 32'h1234_5678);
    chk("jr_if_instr", if_instr, 32'hCC99_5678);

    // Backward branch with 3-cycle ack delay, then decode stalls 5 cycles
    park();
    ack_lat = 3;
    clear_logs();
    redirect(2'b10, 32'h0000_0100, 26'h0, 16'hFFFE, 32'h0);
    wait_valid(20);
    chk("br_req_addr", req_log[0], 32'h0000_00F8);
    chk("br_req_len", 32'(last_req_len), 32'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_if_valid", 32'(if_valid), 32'd1);
      chk("stall_if_instr", if_instr, 32'hDEAD_00F8);
      chk("stall_no_req", 32'(imem_req), 32'd0);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    repeat (3) tick();
    chk("one_pulse_count", 32'(del_log.size()), 32'd1);
    chk("one_pulse_pc", del_log[0].pc, 32'h0000_00F8);
    chk("one_pulse_gone", 32'(if_valid), 32'd0);
    chk("next_seq_addr", imem_addr, 32'h0000_00FC);

    // j target keeps the upper nibble of PC+4
    park();
    ack_lat = 0;
    clear_logs();
    redirect(2'b01, 32'hA000_0010, 26'h000_0040, 16'h0, 32'h0);
    wait_valid(20);
    chk("j_req_addr", req_log[0], 32'hA000_0100);
    chk("j_if_pc", if_pc, 32'hA000_0100);

    // Unaligned jr target: low bits forced to zero
    park();
    clear_logs();
    redirect(2'b11, 32'h0, 26'h0, 16'h0, 32'h0000_0502);
    wait_valid(20);
    chk("unal_req_addr", req_log[0], 32'h0000_0500);
    chk("unal_if_pc", if_pc, 32'h0000_0500);
    chk("unal_if_pc_plus4", if_pc_plus4, 32'h0000_0504);

    // Redirect while WAIT, ack two cycles later: stale word never presented
    park();
    ack_lat = 3;
    clear_logs();
    redirect(2'b11, 32'h0, 26'h0, 16'h0, 32'h0000_0300);
    chk("wait_req_on", 32'(imem_req), 32'd1);
    chk("wait_req_addr", imem_addr, 32'h0000_0300);
    tick();
    redirect(2'b11, 32'h0, 26'h0, 16'h0, 32'h0000_0400);
    id_ready = 1'b1;
    wait_del(1, 40);
    chk("squash_req0", req_log[0], 32'h0000_0300);
    chk("squash_req1", req_log[1], 32'h0000_0400);
    chk("squash_del_pc", del_log[0].pc, 32'h0000_0400);
    chk("squash_del_instr", del_log[0].instr, 32'hDEAD_0400);

    // Wrap from the top of the address space
    park();
    ack_lat = 0;
    clear_logs();
    redirect(2'b11, 32'h0, 26'h0, 16'h0, 32'hFFFF_FFFC);
    wait_valid(20);
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_pc_plus4", if_pc_plus4, 32'h0000_0000);
    id_ready = 1'b1;
    for (int i = 0; i < 20 && req_log.size() < 2; i++) tick();
    chk("wrap_next_req", req_log[1], 32'h0000_0000);

    // Reset in the middle of a WAIT: no squash survives
    park();
    ack_lat = 100;
    redirect(2'b11, 32'h0, 26'h0, 16'h0, 32'h0000_0600);
    tick();
    chk("midwait_req", 32'(imem_req), 32'd1);
    chk("midwait_addr", imem_addr, 32'h0000_0600);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    ack_lat = 0;
    id_ready = 1'b1;
    clear_logs();
    wait_del(1, 20);
    chk("post_rst_req", req_log[0], 32'h0000_0000);
    chk("post_rst_pc", del_log[0].pc, 32'h0000_0000);
    chk("post_rst_instr", del_log[0].instr, 32'hDEAD_0000);

    id_ready = 1'b0;
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
